uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: serial line and consumer handshake in,
// received byte and status flags out.
interface uart_rx_if;
    logic       uart_d_in;
    logic       uart_rx_read;
    logic [7:0] uart_d_out;
    logic       uart_rx_valid;
    logic       uart_rx_overrun;
    logic       uart_frame_err;
    logic       uart_rx_busy;

    modport slave (
        input  uart_d_in,
        input  uart_rx_read,
        output uart_d_out,
        output uart_rx_valid,
        output uart_rx_overrun,
        output uart_frame_err,
        output uart_rx_busy
    );

    modport master (
        output uart_d_in,
        output uart_rx_read,
        input  uart_d_out,
        input  uart_rx_valid,
        input  uart_rx_overrun,
        input  uart_frame_err,
        input  uart_rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit from a synchronized line, holds the
// last good byte with valid/overrun flags and pulses frame_err on a low stop bit.
module uart_rx #(
    parameter logic [23:0] baud_rate  = 24'd4000000,
    parameter logic [27:0] clock_freq = 28'd50000000
) (
    input  logic     uart_clock,
    input  logic     uart_reset,
    uart_rx_if.slave bus
);
    localparam logic [23:0] BIT       = 24'(clock_freq / baud_rate);
    localparam logic [23:0] HALF      = BIT >> 1;
    localparam logic [23:0] BIT_LAST  = BIT - 24'd1;
    localparam logic [23:0] HALF_LAST = HALF - 24'd1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        START_CHECK  = 3'd1,
        RECEIVE_DATA = 3'd2,
        STOP_CHECK   = 3'd3,
        BREAK_WAIT   = 3'd4
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_sync;
    logic [23:0] r_clk_count, w_clk_count_next;
    logic [3:0]  r_bit_count, w_bit_count_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [7:0]  r_d_out, w_d_out_next;
    logic        r_valid, w_valid_next;
    logic        r_overrun, w_overrun_next;
    logic        r_frame_err, w_frame_err_next;
    logic        w_byte_done;
    logic        w_rx_sync;

    assign w_rx_sync = r_sync[1];

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            r_state     <= IDLE;
            r_sync      <= 2'b11;
            r_clk_count <= '0;
            r_bit_count <= '0;
            r_shift     <= '0;
            r_d_out     <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sync      <= {r_sync[0], bus.uart_d_in};
            r_clk_count <= w_clk_count_next;
            r_bit_count <= w_bit_count_next;
            r_shift     <= w_shift_next;
            r_d_out     <= w_d_out_next;
            r_valid     <= w_valid_next;
            r_overrun   <= w_overrun_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clk_count_next = r_clk_count;
        w_bit_count_next = r_bit_count;
        w_shift_next     = r_shift;
        w_frame_err_next = 1'b0;
        w_byte_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_sync) begin
                    w_state_next     = START_CHECK;
                    w_clk_count_next = '0;
                end
            end
            START_CHECK: begin
                if (r_clk_count == HALF_LAST) begin
                    w_clk_count_next = '0;
                    w_bit_count_next = '0;
                    // A start bit that is gone by mid-bit is a glitch.
                    w_state_next = w_rx_sync ? IDLE : RECEIVE_DATA;
                end else begin
                    w_clk_count_next = r_clk_count + 24'd1;
                end
            end
            RECEIVE_DATA: begin
                if (r_clk_count == BIT_LAST) begin
                    w_shift_next     = {w_rx_sync, r_shift[7:1]};
                    w_clk_count_next = '0;
                    w_bit_count_next = r_bit_count + 4'd1;
                    if (r_bit_count == 4'd7) begin
                        w_state_next = STOP_CHECK;
                    end
                end else begin
                    w_clk_count_next = r_clk_count + 24'd1;
                end
            end
            STOP_CHECK: begin
                if (r_clk_count == BIT_LAST) begin
                    w_clk_count_next = '0;
                    if (w_rx_sync) begin
                        w_byte_done  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = BREAK_WAIT;
                    end
                end else begin
                    w_clk_count_next = r_clk_count + 24'd1;
                end
            end
            BREAK_WAIT: begin
                if (w_rx_sync) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A completing byte wins over a read in the same cycle, so valid stays set.
        w_d_out_next   = w_byte_done ? r_shift : r_d_out;
        w_valid_next   = w_byte_done ? 1'b1 : (bus.uart_rx_read ? 1'b0 : r_valid);
        w_overrun_next = r_overrun | (w_byte_done & r_valid & ~bus.uart_rx_read);
    end

    assign bus.uart_d_out      = r_d_out;
    assign bus.uart_rx_valid   = r_valid;
    assign bus.uart_rx_overrun = r_overrun;
    assign bus.uart_frame_err  = r_frame_err;
    assign bus.uart_rx_busy    = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default rates (12 clocks per bit): a frame table
// plus hand-written read, glitch and mid-frame reset sequences.
module tb_uart_rx;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ferr_total;

    uart_rx_if bus ();

    uart_rx u_dut (
        .uart_clock (clk),
        .uart_reset (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.uart_frame_err === 1'b1) ferr_total <= ferr_total + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       pre_reset;
        logic [7:0] data;
        logic       stop;
        int         read_at;
        int         hold_low;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_ferr;
        logic       exp_v116;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.uart_d_in = 1'b1;
        bus.uart_rx_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Start bit is driven just after edge c=0; every bit lasts 12 edges, so the
    // stop sample lands on edge 117 once the 2-flop synchronizer is counted.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int read_at,
                              output logic v116, output logic v117);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        v116 = 1'bx;
        v117 = 1'bx;
        @(posedge clk); #1;
        bus.uart_d_in = bits[0];
        for (int c = 1; c < 120; c++) begin
            @(posedge clk); #1;
            bus.uart_d_in = bits[c / 12];
            if (c == read_at)     bus.uart_rx_read = 1'b1;
            if (c == read_at + 1) bus.uart_rx_read = 1'b0;
            if (c == 116) v116 = bus.uart_rx_valid;
            if (c == 117) v117 = bus.uart_rx_valid;
        end
        @(posedge clk); #1;
        bus.uart_d_in = 1'b1;
        bus.uart_rx_read = 1'b0;
    endtask

    initial begin
        logic v116, v117;
        int   ferr_base;
        logic [9:0] bits;
        checks = 0;
        errors = 0;
        ferr_total = 0;
        rst_n = 1'b0;
        bus.uart_d_in = 1'b1;
        bus.uart_rx_read = 1'b0;

        //            rst   data   stop  rd   hold dout   v     ovr   fe  v116
        vecs[0] = '{1'b1, 8'hA5, 1'b1, -1, 0,  8'hA5, 1'b1, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, -1, 40, 8'h00, 1'b0, 1'b0, 1, 1'b0};
        vecs[2] = '{1'b0, 8'h55, 1'b1, -1, 0,  8'h55, 1'b1, 1'b0, 0, 1'b0};
        vecs[3] = '{1'b1, 8'h11, 1'b1, -1, 0,  8'h11, 1'b1, 1'b0, 0, 1'b0};
        vecs[4] = '{1'b0, 8'h22, 1'b1, -1, 0,  8'h22, 1'b1, 1'b1, 0, 1'b1};
        vecs[5] = '{1'b1, 8'h33, 1'b1, -1, 0,  8'h33, 1'b1, 1'b0, 0, 1'b0};
        vecs[6] = '{1'b0, 8'h7E, 1'b1, 116, 0, 8'h7E, 1'b1, 1'b0, 0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",  32'(bus.uart_d_out), 32'h00);
        check("rst_valid", 32'(bus.uart_rx_valid), 32'h0);
        check("rst_ovr",   32'(bus.uart_rx_overrun), 32'h0);
        check("rst_ferr",  32'(bus.uart_frame_err), 32'h0);
        check("rst_busy",  32'(bus.uart_rx_busy), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pre_reset) do_reset();
            ferr_base = ferr_total;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].read_at, v116, v117);
            if (vecs[i].hold_low > 0) begin
                bus.uart_d_in = 1'b0;
                repeat (vecs[i].hold_low) @(posedge clk);
                #1;
                check($sformatf("v%0d_busy_break", i), 32'(bus.uart_rx_busy), 32'h1);
                bus.uart_d_in = 1'b1;
            end
            repeat (5) @(posedge clk);
            #1;
            $display("vec %0d data=%02h stop=%0b dout=%02h valid=%0b ovr=%0b ferr=%0d",
                     i, vecs[i].data, vecs[i].stop, bus.uart_d_out, bus.uart_rx_valid,
                     bus.uart_rx_overrun, ferr_total - ferr_base);
            check($sformatf("v%0d_dout", i),  32'(bus.uart_d_out), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d_valid", i), 32'(bus.uart_rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ovr", i),   32'(bus.uart_rx_overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_ferr", i),  32'(ferr_total - ferr_base), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_v116", i),  32'(v116), 32'(vecs[i].exp_v116));
            check($sformatf("v%0d_v117", i),  32'(v117), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_busy", i),  32'(bus.uart_rx_busy), 32'h0);
        end

        // Read handshake, idle read, then a short low glitch.
        do_reset();
        ferr_base = ferr_total;
        send_frame(8'hA5, 1'b1, -1, v116, v117);
        repeat (3) @(posedge clk);
        #1;
        bus.uart_rx_read = 1'b1;
        check("rd_pre_valid", 32'(bus.uart_rx_valid), 32'h1);
        @(posedge clk); #1;
        bus.uart_rx_read = 1'b0;
        check("rd_valid_clr", 32'(bus.uart_rx_valid), 32'h0);
        check("rd_dout", 32'(bus.uart_d_out), 32'hA5);
        $display("read: dout=%02h valid=%0b", bus.uart_d_out, bus.uart_rx_valid);
        bus.uart_rx_read = 1'b1;
        @(posedge clk); #1;
        bus.uart_rx_read = 1'b0;
        @(posedge clk); #1;
        check("idle_rd_valid", 32'(bus.uart_rx_valid), 32'h0);
        check("idle_rd_ovr", 32'(bus.uart_rx_overrun), 32'h0);
        $display("idle read: valid=%0b ovr=%0b", bus.uart_rx_valid, bus.uart_rx_overrun);
        bus.uart_d_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.uart_d_in = 1'b1;
        check("glitch_busy_hi", 32'(bus.uart_rx_busy), 32'h1);
        repeat (15) @(posedge clk);
        #1;
        $display("glitch: busy=%0b valid=%0b dout=%02h", bus.uart_rx_busy, bus.uart_rx_valid, bus.uart_d_out);
        check("glitch_busy_lo", 32'(bus.uart_rx_busy), 32'h0);
        check("glitch_valid", 32'(bus.uart_rx_valid), 32'h0);
        check("glitch_dout", 32'(bus.uart_d_out), 32'hA5);
        check("glitch_ferr", 32'(ferr_total - ferr_base), 32'h0);

        // Reset during data bit 4 of 0xF0 with overrun already set.
        do_reset();
        send_frame(8'h11, 1'b1, -1, v116, v117);
        repeat (3) @(posedge clk);
        send_frame(8'h12, 1'b1, -1, v116, v117);
        repeat (3) @(posedge clk);
        #1;
        check("pre_mid_ovr", 32'(bus.uart_rx_overrun), 32'h1);
        bits = {1'b1, 8'hF0, 1'b0};
        @(posedge clk); #1;
        bus.uart_d_in = bits[0];
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk); #1;
            bus.uart_d_in = bits[c / 12];
        end
        rst_n = 1'b0;
        #1;
        $display("mid reset: dout=%02h valid=%0b ovr=%0b ferr=%0b busy=%0b", bus.uart_d_out,
                 bus.uart_rx_valid, bus.uart_rx_overrun, bus.uart_frame_err, bus.uart_rx_busy);
        check("mid_rst_dout", 32'(bus.uart_d_out), 32'h00);
        check("mid_rst_valid", 32'(bus.uart_rx_valid), 32'h0);
        check("mid_rst_ovr", 32'(bus.uart_rx_overrun), 32'h0);
        check("mid_rst_ferr", 32'(bus.uart_frame_err), 32'h0);
        check("mid_rst_busy", 32'(bus.uart_rx_busy), 32'h0);
        bus.uart_d_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ferr_base = ferr_total;
        send_frame(8'h81, 1'b1, -1, v116, v117);
        repeat (5) @(posedge clk);
        #1;
        $display("after reset: dout=%02h valid=%0b ovr=%0b", bus.uart_d_out, bus.uart_rx_valid, bus.uart_rx_overrun);
        check("post_rst_dout", 32'(bus.uart_d_out), 32'h81);
        check("post_rst_valid", 32'(bus.uart_rx_valid), 32'h1);
        check("post_rst_ovr", 32'(bus.uart_rx_overrun), 32'h0);
        check("post_rst_ferr", 32'(ferr_total - ferr_base), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
